// File: rtl/imm_pkg.sv
// Shared types and constants for the pipelined immediate generator.
// Selector codes, plus the XLEN legality check used at elaboration.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_U     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_ZIMM  = 3'b110,
    IMM_ILL   = 3'b111
  } immsrc_e;

  function automatic bit xlen_ok(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

  function automatic int entry_w(input int xlen, input int tag_w);
    return xlen + tag_w + 1;
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder for all RV32/RV64 formats.
// instr_i carries instruction bits [31:7], so bit n of the instruction is instr_i[n-7].
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [24:0]     instr_i,
  input  logic [2:0]      immsrc_i,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);

  // Signed size casts perform the sign extension from instruction bit 31.
  always_comb begin
    imm_o     = '0;
    illegal_o = 1'b0;
    case (immsrc_e'(immsrc_i))
      IMM_I:     imm_o = XLEN'($signed(instr_i[24:13]));
      IMM_S:     imm_o = XLEN'($signed({instr_i[24:18], instr_i[4:0]}));
      IMM_B:     imm_o = XLEN'($signed({instr_i[24], instr_i[0], instr_i[23:18],
                                        instr_i[4:1], 1'b0}));
      IMM_J:     imm_o = XLEN'($signed({instr_i[24], instr_i[12:5], instr_i[13],
                                        instr_i[23:14], 1'b0}));
      IMM_U:     imm_o = XLEN'($signed({instr_i[24:5], 12'b0}));
      IMM_SHAMT: imm_o = (XLEN == 64) ? XLEN'(instr_i[18:13]) : XLEN'(instr_i[17:13]);
      IMM_ZIMM:  imm_o = XLEN'(instr_i[12:8]);
      IMM_ILL:   illegal_o = 1'b1;
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode, then an output register backed by a
// skid register so in_ready_o never depends combinationally on out_ready_i.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [24:0]      instr_i,
  input  logic [2:0]       immsrc_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  immext_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             illegal_o
);

  if (!xlen_ok(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  // State encoding is the occupancy pair {OUT valid, SKID valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } occ_e;

  occ_e            state_q, state_d;
  entry_t          out_q, skid_q, in_entry;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic            in_xfer, out_xfer;
  logic            load_out_in, load_out_skid, load_skid;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i   (instr_i),
    .immsrc_i  (immsrc_i),
    .imm_o     (dec_imm),
    .illegal_o (dec_illegal)
  );

  assign in_entry    = '{imm: dec_imm, tag: tag_i, illegal: dec_illegal};
  assign out_valid_o = state_q[1];
  assign in_ready_o  = ~state_q[0];
  assign in_xfer     = in_valid_i & in_ready_o;
  assign out_xfer    = out_valid_o & out_ready_i;

  always_comb begin
    state_d       = state_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_xfer) begin
          load_out_in = 1'b1;
          state_d     = ONE;
        end
        ONE: if (out_xfer) begin
          load_out_in = in_xfer;
          state_d     = in_xfer ? ONE : EMPTY;
        end else if (in_xfer) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end
        FULL: if (out_xfer) begin
          load_out_skid = 1'b1;
          state_d       = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Data registers only load on a transfer so outputs hold while stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out_in)        out_q <= in_entry;
      else if (load_out_skid) out_q <= skid_q;
      if (load_skid)          skid_q <= in_entry;
    end
  end

  assign immext_o  = out_q.imm;
  assign tag_o     = out_q.tag;
  assign illegal_o = out_q.illegal;

endmodule
